// File: rtl/pit_data_responder.sv
// rtl/pit_data_responder.sv - pending-interest table that answers FIB data offers and forwards the data bytes
module pit_data_responder #(
  parameter int NUM_ENTRIES = 8,
  parameter int DATA_BYTES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] fib_prefix,
  input  logic [5:0]  fib_len,
  input  logic        fib_prefix_ready,
  input  logic [7:0]  fib_data,
  input  logic        interest_valid,
  input  logic [63:0] interest_prefix,
  input  logic [5:0]  interest_len,
  input  logic [3:0]  interest_port,
  output logic        rejected,
  output logic        start_send_to_pit,
  output logic [7:0]  data_out,
  output logic        data_out_valid,
  output logic [3:0]  data_out_ports,
  output logic        busy,
  output logic        table_full
);

  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_ENTRIES - 1);
  localparam logic [9:0]    LAST_BYTE = 10'(DATA_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SCAN, ACCEPT, REJECT, XFER} state_t;

  state_t state, state_nxt;

  logic [NUM_ENTRIES-1:0] ent_valid;
  logic [63:0]            ent_prefix [NUM_ENTRIES];
  logic [5:0]             ent_len    [NUM_ENTRIES];
  logic [3:0]             ent_ports  [NUM_ENTRIES];

  logic [63:0]   offer_prefix;
  logic [5:0]    offer_len;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] hit_idx;
  logic [3:0]    hit_ports;
  logic [9:0]    byte_cnt;

  logic          scan_hit;
  logic          last_byte;
  logic          ins_hit;
  logic [IW-1:0] ins_hit_idx;
  logic          ins_free;
  logic [IW-1:0] ins_free_idx;

  // Compare the single entry under the scan pointer with the latched offer.
  always_comb begin
    scan_hit  = ent_valid[scan_idx] && (ent_prefix[scan_idx] == offer_prefix) &&
                (ent_len[scan_idx] == offer_len);
    last_byte = (byte_cnt == LAST_BYTE);
  end

  // Insert lookup on pre-edge valid bits: existing match, else lowest free slot.
  always_comb begin
    ins_hit      = 1'b0;
    ins_hit_idx  = '0;
    ins_free     = 1'b0;
    ins_free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ent_valid[i] && (ent_prefix[i] == interest_prefix) && (ent_len[i] == interest_len)) begin
        ins_hit     = 1'b1;
        ins_hit_idx = IW'(i);
      end
      if (!ent_valid[i]) begin
        ins_free     = 1'b1;
        ins_free_idx = IW'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; offers are only heard in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fib_prefix_ready) state_nxt = SCAN;
      SCAN: begin
        if (scan_hit)                   state_nxt = ACCEPT;
        else if (scan_idx == LAST_IDX)  state_nxt = REJECT;
      end
      ACCEPT:  state_nxt = XFER;
      REJECT:  state_nxt = IDLE;
      XFER:    if (last_byte) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Valid bits: set by inserts into free slots, cleared when a transfer completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
    end else begin
      if (interest_valid && !ins_hit && ins_free) ent_valid[ins_free_idx] <= 1'b1;
      if (state == XFER && last_byte)             ent_valid[hit_idx]      <= 1'b0;
    end
  end

  // Entry payload: merge ports into a matching entry or fill a free slot.
  always_ff @(posedge clk) begin
    if (interest_valid) begin
      if (ins_hit) begin
        ent_ports[ins_hit_idx] <= ent_ports[ins_hit_idx] | interest_port;
      end else if (ins_free) begin
        ent_prefix[ins_free_idx] <= interest_prefix;
        ent_len[ins_free_idx]    <= interest_len;
        ent_ports[ins_free_idx]  <= interest_port;
      end
    end
  end

  // Offer latch, scan pointer, hit capture and byte counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offer_prefix <= '0;
      offer_len    <= '0;
      scan_idx     <= '0;
      hit_idx      <= '0;
      hit_ports    <= '0;
      byte_cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (fib_prefix_ready) begin
          offer_prefix <= fib_prefix;
          offer_len    <= fib_len;
          scan_idx     <= '0;
        end
        SCAN: begin
          if (scan_hit) begin
            hit_idx   <= scan_idx;
            hit_ports <= ent_ports[scan_idx];
          end else if (scan_idx != LAST_IDX) begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        ACCEPT:  byte_cnt <= '0;
        XFER:    byte_cnt <= byte_cnt + 10'd1;
        default: ;
      endcase
    end
  end

  // Registered data path: the byte sampled in XFER shows up one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_ports <= '0;
    end else begin
      data_out       <= (state == XFER) ? fib_data  : 8'd0;
      data_out_valid <= (state == XFER);
      data_out_ports <= (state == XFER) ? hit_ports : 4'd0;
    end
  end

  // Pulses and status decoded straight from the current state and table.
  always_comb begin
    rejected          = (state == REJECT);
    start_send_to_pit = (state == ACCEPT);
    busy              = (state != IDLE);
    table_full        = &ent_valid;
  end

endmodule

// File: doc/pit_data_responder.md
PIT_DATA_RESPONDER -- requirements
Module: pit_data_responder

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8, number of pending-interest entries.
REQ-002 SHALL have parameter DATA_BYTES, default 1024, bytes per data transfer.
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fib_prefix  in  64  prefix offered by FIB.
- fib_len  in  6  prefix length offered by FIB.
- fib_prefix_ready  in  1  FIB offer strobe.
- fib_data  in  8  data byte stream from FIB.
- interest_valid  in  1  pending-interest insert strobe.
- interest_prefix  in  64  prefix to insert.
- interest_len  in  6  length to insert.
- interest_port  in  4  requesting-interface bitmask.
- rejected  out  1  one-cycle reject pulse to FIB.
- start_send_to_pit  out  1  one-cycle accept pulse to FIB.
- data_out  out  8  forwarded data byte.
- data_out_valid  out  1  data_out qualifier.
- data_out_ports  out  4  destination bitmask for data_out.
- busy  out  1  high whenever state is not IDLE.
- table_full  out  1  high when all entries are valid.

Function
REQ-004 SHALL hold NUM_ENTRIES entries, each {valid, prefix[63:0], len[5:0], ports[3:0]}; match = valid AND prefix equal AND len equal (len 0 is legal).
REQ-005 SHALL implement states IDLE, SCAN, ACCEPT, REJECT, XFER.
REQ-006 IDLE: on fib_prefix_ready=1, latch fib_prefix/fib_len and set scan index to 0 -> SCAN; fib_prefix_ready SHALL be ignored in all other states.
REQ-007 SCAN: examine one entry per cycle at the scan index; on match, latch index and ports -> ACCEPT; on miss with index = NUM_ENTRIES-1 -> REJECT; otherwise increment the index.
REQ-008 Latency: offer-to-response is 2..NUM_ENTRIES+1 cycles after the offer edge (hit at entry k: pulse in cycle k+2; full miss: pulse in cycle NUM_ENTRIES+1).
REQ-009 REJECT: rejected=1 for exactly one cycle -> IDLE; table is unchanged.
REQ-010 ACCEPT: start_send_to_pit=1 for exactly one cycle; clear byte counter -> XFER.
REQ-011 XFER: lasts exactly DATA_BYTES cycles; each edge in XFER samples fib_data.
REQ-012 data_out SHALL be registered: sampled byte appears next cycle with data_out_valid=1 and data_out_ports = latched ports.
REQ-013 data_out_valid SHALL therefore be high for DATA_BYTES consecutive cycles and 0 otherwise; data_out=0 when not valid.
REQ-014 Byte counter SHALL be 10 bits wide and wrap 1023->0 on the last byte.
REQ-015 On the last XFER edge, SHALL clear the hit entry's valid bit -> IDLE.
REQ-016 Insert (any state), on interest_valid=1: if a matching entry exists, OR interest_port into its ports; else write to the lowest-index invalid entry; if none, drop silently.
REQ-017 Free-slot and merge decisions SHALL use pre-edge valid bits; the slot cleared on the last XFER edge is not reusable in that same cycle.
REQ-018 A merge into the entry under transfer SHALL NOT change data_out_ports for that transfer; the entry is still cleared at the end.
REQ-019 An insert during SCAN into an already-passed index SHALL NOT be found by the current scan.
REQ-020 table_full and busy SHALL be combinational from current state.

Reset
REQ-021 rst=1 SHALL immediately force: state IDLE; all valid bits 0; counters 0; rejected, start_send_to_pit, data_out, data_out_valid, data_out_ports all 0.
REQ-022 Reset mid-SCAN or mid-XFER SHALL abort the operation with no further pulses or data.

Verification
REQ-023 Insert {prefix 0xA5, len 8, port 0010}; offer same prefix/len -> start_send_to_pit pulse 2 cycles later; 1024 bytes of ramp 0..255 appear on data_out with ports 0010; entry is invalid afterwards.
REQ-024 Empty table, offer any prefix -> rejected pulse in cycle 9; no data_out_valid; busy low after.
REQ-025 Insert same prefix twice with ports 0001 then 0100 -> single entry; transfer carries ports 0101.
REQ-026 Fill 8 entries, insert a 9th -> table_full=1 and 9th dropped; transfer entry 3 -> table_full drops after the last byte.
REQ-027 Assert rst at byte 500 of XFER -> all outputs 0 immediately; a later offer of the same prefix is rejected.
REQ-028 Pulse fib_prefix_ready during XFER -> ignored; transfer count stays exactly 1024.
